// File: rtl/cpubus_init_cc.sv
// Processor-bus initiator: turns a one-cycle local read/write request into a
// single pce_/prnw bus cycle (setup, strobe, hold) and returns a one-cycle ack.
module cpubus_init_cc #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int SETUP  = 2,
    parameter int STROBE = 12,
    parameter int HOLD   = 2
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req,
    input  logic          rnw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          pce_,
    output logic          prnw,
    output logic [AW-1:0] pa,
    output logic [DW-1:0] pdo,
    output logic          pdoe,
    input  logic [DW-1:0] pdi
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STRB, S_HOLD} state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD - 1);

    state_t        state_reg, state_next;
    logic [7:0]    count_reg, count_next;
    logic          busy_reg, busy_next;
    logic          ack_reg, ack_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    logic          pce_reg, pce_next;
    logic          prnw_reg, prnw_next;
    logic [AW-1:0] pa_reg, pa_next;
    logic [DW-1:0] pdo_reg, pdo_next;
    logic          pdoe_reg, pdoe_next;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
            pce_reg   <= 1'b1;
            prnw_reg  <= 1'b1;
            pa_reg    <= '0;
            pdo_reg   <= '0;
            pdoe_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            pce_reg   <= pce_next;
            prnw_reg  <= prnw_next;
            pa_reg    <= pa_next;
            pdo_reg   <= pdo_next;
            pdoe_reg  <= pdoe_next;
        end
    end

    // Every registered output holds unless the current phase says otherwise;
    // the bus side is therefore frozen for the whole strobe.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        busy_next  = busy_reg;
        ack_next   = 1'b0;
        rdata_next = rdata_reg;
        pce_next   = pce_reg;
        prnw_next  = prnw_reg;
        pa_next    = pa_reg;
        pdo_next   = pdo_reg;
        pdoe_next  = pdoe_reg;
        case (state_reg)
            S_IDLE: begin
                pce_next = 1'b1;
                if (req) begin
                    pa_next    = addr;
                    prnw_next  = rnw;
                    pdo_next   = wdata;
                    pdoe_next  = ~rnw;
                    busy_next  = 1'b1;
                    count_next = SETUP_LD;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (count_reg == 8'd0) begin
                    pce_next   = 1'b0;
                    count_next = STROBE_LD;
                    state_next = S_STRB;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            S_STRB: begin
                if (count_reg == 8'd0) begin
                    pce_next = 1'b1;
                    // pdi is taken from the final strobe cycle, when the slave has settled
                    if (prnw_reg) begin
                        rdata_next = pdi;
                    end
                    count_next = HOLD_LD;
                    state_next = S_HOLD;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            S_HOLD: begin
                if (count_reg == 8'd0) begin
                    busy_next  = 1'b0;
                    ack_next   = 1'b1;
                    pdoe_next  = 1'b0;
                    prnw_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            default: begin
                pce_next   = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy  = busy_reg;
    assign ack   = ack_reg;
    assign rdata = rdata_reg;
    assign pce_  = pce_reg;
    assign prnw  = prnw_reg;
    assign pa    = pa_reg;
    assign pdo   = pdo_reg;
    assign pdoe  = pdoe_reg;

endmodule

// File: tb/tb_cpubus_init_cc.sv
// Directed bench for cpubus_init_cc: a default-parameter instance (a) and a
// minimum-timing instance (b), each watched by a simple slave strobe monitor.
module tb_cpubus_init_cc;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 0, rnw_a = 0, req_b = 0, rnw_b = 0;
    logic [15:0] addr_a = 0, wdata_a = 0, pdi_a = 0;
    logic [15:0] addr_b = 0, wdata_b = 0, pdi_b = 0;
    logic        busy_a, ack_a, pce_a, prnw_a, pdoe_a;
    logic        busy_b, ack_b, pce_b, prnw_b, pdoe_b;
    logic [15:0] rdata_a, pa_a, pdo_a, rdata_b, pa_b, pdo_b;

    cpubus_init_cc dut_a (
        .clk(clk), .rst_(rst_), .req(req_a), .rnw(rnw_a), .addr(addr_a), .wdata(wdata_a),
        .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .pce_(pce_a), .prnw(prnw_a),
        .pa(pa_a), .pdo(pdo_a), .pdoe(pdoe_a), .pdi(pdi_a)
    );

    cpubus_init_cc #(.SETUP(2), .STROBE(6), .HOLD(1)) dut_b (
        .clk(clk), .rst_(rst_), .req(req_b), .rnw(rnw_b), .addr(addr_b), .wdata(wdata_b),
        .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .pce_(pce_b), .prnw(prnw_b),
        .pa(pa_b), .pdo(pdo_b), .pdoe(pdoe_b), .pdi(pdi_b)
    );

    int checks = 0;
    int errors = 0;

    // Slave-side view of each bus: strobe counts by direction, low/high run
    // lengths, and any pa/prnw movement while pce_ is low.
    logic pce_v [2];
    logic prnw_v [2];
    logic ack_v [2];
    logic [15:0] pa_v [2];
    assign pce_v[0] = pce_a;  assign pce_v[1] = pce_b;
    assign prnw_v[0] = prnw_a; assign prnw_v[1] = prnw_b;
    assign ack_v[0] = ack_a;  assign ack_v[1] = ack_b;
    assign pa_v[0] = pa_a;    assign pa_v[1] = pa_b;

    logic        prev [2] = '{1'b1, 1'b1};
    int          prs [2] = '{0, 0};
    int          pws [2] = '{0, 0};
    int          acks [2] = '{0, 0};
    int          lo_run [2] = '{0, 0};
    int          hi_run [2] = '{0, 0};
    int          last_low [2] = '{0, 0};
    int          last_gap [2] = '{0, 0};
    int          viol [2] = '{0, 0};
    logic [15:0] pa_at [2];
    logic        prnw_at [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev[i] <= pce_v[i];
            if (ack_v[i]) acks[i] <= acks[i] + 1;
            if (prev[i] && !pce_v[i]) begin
                if (prnw_v[i]) prs[i] <= prs[i] + 1;
                else           pws[i] <= pws[i] + 1;
                last_gap[i] <= hi_run[i];
                hi_run[i]   <= 0;
                lo_run[i]   <= 1;
                pa_at[i]    <= pa_v[i];
                prnw_at[i]  <= prnw_v[i];
            end else if (!pce_v[i]) begin
                lo_run[i] <= lo_run[i] + 1;
                if (pa_v[i] !== pa_at[i] || prnw_v[i] !== prnw_at[i]) viol[i] <= viol[i] + 1;
            end else begin
                hi_run[i] <= hi_run[i] + 1;
                if (!prev[i]) last_low[i] <= lo_run[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic q, input logic r,
                         input logic [15:0] a, input logic [15:0] w);
        if (sel == 0) begin
            req_a = q; rnw_a = r; addr_a = a; wdata_a = w;
        end else begin
            req_b = q; rnw_b = r; addr_b = a; wdata_b = w;
        end
    endtask

    // Issues one request now (inputs seen at the next edge, edge 0) and checks
    // every cycle through the ack edge. ign>0 re-asserts req with a different
    // address at that edge, which must be ignored.
    task automatic xfer(input int sel, input logic r, input logic [15:0] a,
                        input logic [15:0] w, input logic [15:0] exp_rd, input int ign);
        int st, lat;
        logic o_pce, o_ack, o_busy, o_pdoe, o_prnw;
        logic [15:0] o_pa, o_pdo, o_rd;
        st  = (sel == 0) ? 12 : 6;
        lat = (sel == 0) ? 16 : 9;
        drive(sel, 1'b1, r, a, w);
        for (int e = 0; e <= lat; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e + 1 == ign) drive(sel, 1'b1, ~r, 16'hDEAD, 16'h0BAD);
            else              drive(sel, 1'b0, r, a, w);
            o_pce  = (sel == 0) ? pce_a  : pce_b;
            o_ack  = (sel == 0) ? ack_a  : ack_b;
            o_busy = (sel == 0) ? busy_a : busy_b;
            o_pdoe = (sel == 0) ? pdoe_a : pdoe_b;
            o_prnw = (sel == 0) ? prnw_a : prnw_b;
            o_pa   = (sel == 0) ? pa_a   : pa_b;
            o_pdo  = (sel == 0) ? pdo_a  : pdo_b;
            o_rd   = (sel == 0) ? rdata_a : rdata_b;
            chk($sformatf("pce_ i%0d e%0d", sel, e), 32'(o_pce), 32'(!(e >= 2 && e < 2 + st)));
            chk($sformatf("ack i%0d e%0d", sel, e), 32'(o_ack), 32'(e == lat));
            chk($sformatf("busy i%0d e%0d", sel, e), 32'(o_busy), 32'(e < lat));
            chk($sformatf("pdoe i%0d e%0d", sel, e), 32'(o_pdoe), 32'((e < lat) && !r));
            chk($sformatf("prnw i%0d e%0d", sel, e), 32'(o_prnw), 32'((e < lat) ? r : 1'b1));
            chk($sformatf("pa i%0d e%0d", sel, e), 32'(o_pa), 32'(a));
            chk($sformatf("pdo i%0d e%0d", sel, e), 32'(o_pdo), 32'(w));
            if (e == lat) chk($sformatf("rdata i%0d", sel), 32'(o_rd), 32'(exp_rd));
        end
    endtask

    int f0, w0, r0, a0;

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst ack", 32'(ack_a), 32'd0);
        chk("rst pce_", 32'(pce_a), 32'd1);
        chk("rst prnw", 32'(prnw_a), 32'd1);
        chk("rst pa", 32'(pa_a), 32'd0);
        chk("rst pdo", 32'(pdo_a), 32'd0);
        chk("rst pdoe", 32'(pdoe_a), 32'd0);
        chk("rst rdata", 32'(rdata_a), 32'd0);
        chk("rst b pce_", 32'(pce_b), 32'd1);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);

        // Write with default timing
        w0 = pws[0]; r0 = prs[0]; a0 = acks[0];
        xfer(0, 1'b0, 16'h1234, 16'hA5A5, 16'h0000, 0);
        @(negedge clk);
        chk("wr pws", 32'(pws[0] - w0), 32'd1);
        chk("wr prs", 32'(prs[0] - r0), 32'd0);
        chk("wr acks", 32'(acks[0] - a0), 32'd1);
        chk("wr low len", 32'(last_low[0]), 32'd12);
        chk("wr pa after", 32'(pa_a), 32'h1234);

        // Read with default timing
        pdi_a = 16'hBEEF;
        w0 = pws[0]; r0 = prs[0];
        xfer(0, 1'b1, 16'h0042, 16'h0000, 16'hBEEF, 0);
        @(negedge clk);
        chk("rd prs", 32'(prs[0] - r0), 32'd1);
        chk("rd pws", 32'(pws[0] - w0), 32'd0);
        chk("rd low len", 32'(last_low[0]), 32'd12);

        // Second request during the transfer is dropped; rdata untouched by a write
        pdi_a = 16'h1111;
        f0 = pws[0] + prs[0]; a0 = acks[0];
        xfer(0, 1'b0, 16'h00F0, 16'h5A5A, 16'hBEEF, 5);
        repeat (20) @(negedge clk);
        chk("ign strobes", 32'(pws[0] + prs[0] - f0), 32'd1);
        chk("ign acks", 32'(acks[0] - a0), 32'd1);
        chk("ign busy", 32'(busy_a), 32'd0);
        chk("ign rdata", 32'(rdata_a), 32'hBEEF);

        // Back-to-back: new req presented while ack is high. pce_ stays high
        // from the rise at edge 14 through edge 18 of the first transfer.
        pdi_a = 16'hC3C3;
        xfer(0, 1'b0, 16'h0101, 16'h0202, 16'hBEEF, 0);
        xfer(0, 1'b1, 16'h0303, 16'h0000, 16'hC3C3, 0);
        @(negedge clk);
        chk("b2b gap", 32'(last_gap[0]), 32'd5);

        // Minimum timing instance
        pdi_b = 16'h7E57;
        w0 = pws[1]; r0 = prs[1]; a0 = acks[1];
        xfer(1, 1'b0, 16'hABCD, 16'h9876, 16'h0000, 0);
        @(negedge clk);
        chk("min wr pws", 32'(pws[1] - w0), 32'd1);
        chk("min wr low len", 32'(last_low[1]), 32'd6);
        xfer(1, 1'b1, 16'h0F0F, 16'h0000, 16'h7E57, 0);
        @(negedge clk);
        chk("min rd prs", 32'(prs[1] - r0), 32'd1);
        chk("min rd low len", 32'(last_low[1]), 32'd6);
        chk("min acks", 32'(acks[1] - a0), 32'd2);

        // Asynchronous reset in the middle of the strobe
        a0 = acks[0];
        drive(0, 1'b1, 1'b0, 16'h7777, 16'h8888);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 16'h7777, 16'h8888);
        end
        chk("mid pce_ low", 32'(pce_a), 32'd0);
        #2 rst_ = 1'b0;
        #1;
        chk("arst pce_", 32'(pce_a), 32'd1);
        chk("arst busy", 32'(busy_a), 32'd0);
        chk("arst pdoe", 32'(pdoe_a), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst no ack", 32'(acks[0] - a0), 32'd0);
        chk("arst pa", 32'(pa_a), 32'd0);
        chk("arst prnw", 32'(prnw_a), 32'd1);
        chk("arst rdata", 32'(rdata_a), 32'd0);
        chk("arst pce_ idle", 32'(pce_a), 32'd1);

        chk("stable a", 32'(viol[0]), 32'd0);
        chk("stable b", 32'(viol[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
